// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and the hex glyph table for the UART/7-segment block.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Active-low {g,f,e,d,c,b,a}; entry n at bits [7n+6:7n], glyphs 0-9, A, b, C, d, E, F.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Free-running down-counter emitting a one-cycle oversample tick every SAMPLE_DIV clocks.
module uart_sample_tick #(
    parameter int SAMPLE_DIV = 54
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic sample_tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CW-1:0] div_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            div_cnt <= '0;
        else if (div_cnt == '0)
            div_cnt <= CW'(SAMPLE_DIV - 1);
        else
            div_cnt <= div_cnt - 1'b1;
    end

    assign sample_tick = (div_cnt == '0);

endmodule

// File: rtl/uart_rx_tx_seg.sv
// 8N1 UART receiver and transmitter sharing one oversample tick, plus a 4-digit hex display driver.
//  state    | meaning
//  *_IDLE   | line idle; RX waits for a low sample, TX waits for tx_enable
//  *_START  | start bit; RX re-checks at mid-bit, TX drives 0
//  *_DATA   | 8 data bits, LSB first, one per OVERSAMPLE ticks
//  *_STOP   | stop bit; RX samples it and posts the byte, TX drives 1
module uart_rx_tx_seg #(
    parameter int SAMPLE_DIV        = 54,
    parameter int OVERSAMPLE        = 16,
    parameter int INPUT_WIDTH       = 16,
    parameter int SEV_SEG_PRESCALAR = 18
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   rx,
    input  logic                   flush,
    output logic [7:0]             data,
    output logic                   converted,
    output logic                   data_valid,
    output logic                   rx_busy,
    input  logic                   tx_enable,
    input  logic [7:0]             tx_data,
    output logic                   tx,
    output logic                   tx_busy,
    input  logic [INPUT_WIDTH-1:0] number,
    input  logic [3:0]             decimal_points,
    output logic [3:0]             anodes,
    output logic [7:0]             cathodes
);
    import uart_pkg::*;

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0]  FULL_LOAD = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_LOAD = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic sample_tick;

    uart_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .sample_tick (sample_tick)
    );

    logic [1:0] rx_sync;
    logic       rx_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rx_sync <= 2'b11;
        else       rx_sync <= {rx_sync[0], rx};
    end
    assign rx_s = rx_sync[1];

    rx_state_t            rx_state, rx_nxt;
    logic [OS_W-1:0]      rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_expire, rx_done;

    assign rx_expire = sample_tick && (rx_cnt == '0);
    assign rx_done   = (rx_state == RX_STOP) && rx_expire;

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (sample_tick && !rx_s) rx_nxt = RX_START;
            RX_START: if (rx_expire) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_expire && rx_bit == LAST_BIT) rx_nxt = RX_STOP;
            RX_STOP:  if (rx_expire) rx_nxt = RX_IDLE;
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rx_state <= RX_IDLE;
        else       rx_state <= rx_nxt;
    end

    // The half-bit load in IDLE lines the first expiry up with the middle of the start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_cnt <= HALF_LOAD;
            rx_bit <= '0;
        end else if (rx_expire) begin
            rx_cnt <= FULL_LOAD;
            if (rx_state == RX_DATA) begin
                rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end else if (sample_tick) begin
            rx_cnt <= rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data       <= '0;
            converted  <= 1'b0;
            data_valid <= 1'b0;
        end else if (rx_done) begin
            data       <= rx_shreg;
            converted  <= 1'b1;
            data_valid <= rx_s;
        end else if (flush) begin
            converted  <= 1'b0;
            data_valid <= 1'b0;
        end
    end

    assign rx_busy = (rx_state != RX_IDLE);

    tx_state_t            tx_state, tx_nxt;
    logic [OS_W-1:0]      tx_cnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_expire;

    assign tx_expire = sample_tick && (tx_cnt == '0);

    always_comb begin
        tx_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_enable) tx_nxt = TX_START;
            TX_START: if (tx_expire) tx_nxt = TX_DATA;
            TX_DATA:  if (tx_expire && tx_bit == LAST_BIT) tx_nxt = TX_STOP;
            TX_STOP:  if (tx_expire) tx_nxt = TX_IDLE;
            default:  tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) tx_state <= TX_IDLE;
        else       tx_state <= tx_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_cnt <= FULL_LOAD;
            tx_bit <= '0;
            if (tx_enable) tx_shreg <= tx_data;
        end else if (tx_expire) begin
            tx_cnt <= FULL_LOAD;
            if (tx_state == TX_DATA) begin
                tx_shreg <= {1'b0, tx_shreg[DATA_BITS-1:1]};
                tx_bit   <= tx_bit + 1'b1;
            end
        end else if (sample_tick) begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

    assign tx      = (tx_state == TX_START) ? 1'b0 :
                     (tx_state == TX_DATA)  ? tx_shreg[0] : 1'b1;
    assign tx_busy = (tx_state != TX_IDLE);

    logic [SEV_SEG_PRESCALAR-1:0] seg_cnt;
    logic [1:0]                   digit;
    logic [15:0]                  num16;
    logic [3:0]                   nibble;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) seg_cnt <= '0;
        else       seg_cnt <= seg_cnt + 1'b1;
    end

    assign digit    = seg_cnt[SEV_SEG_PRESCALAR-1 -: 2];
    assign num16    = number[15:0];
    assign nibble   = num16[{digit, 2'b00} +: 4];
    assign anodes   = ~(4'b0001 << digit);
    assign cathodes = {~decimal_points[digit], hex_to_seg(nibble)};

endmodule

// File: tb/tb_uart_rx_tx_seg.sv
// Directed self-checking bench for uart_rx_tx_seg: RX frames, glitch, flush, TX waveform, display, reset.
module tb_uart_rx_tx_seg;

    localparam int BIT_CLKS = 864;
    localparam int TICK_DIV = 54;
    localparam int DIG_CLKS = 1024;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       rx = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] data;
    logic       converted, data_valid, rx_busy;
    logic       tx_enable = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_busy;
    logic [15:0] number = 16'h0003;
    logic [3:0] decimal_points = 4'b0000;
    logic [3:0] anodes;
    logic [7:0] cathodes;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    // Clocks since reset release; tick edges are cyc % 54 == 1, display digit is cyc[11:10].
    always @(posedge clk or posedge i_rst) begin
        if (i_rst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    uart_rx_tx_seg #(
        .SAMPLE_DIV(54), .OVERSAMPLE(16), .INPUT_WIDTH(16), .SEV_SEG_PRESCALAR(12)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .rx(rx), .flush(flush), .data(data),
        .converted(converted), .data_valid(data_valid), .rx_busy(rx_busy),
        .tx_enable(tx_enable), .tx_data(tx_data), .tx(tx), .tx_busy(tx_busy),
        .number(number), .decimal_points(decimal_points),
        .anodes(anodes), .cathodes(cathodes)
    );

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(posedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLKS) @(posedge clk);
        rx = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
        checks++; if (converted !== 1'b0) begin errors++; $display("FAIL reset_converted got %b want 0", converted); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (anodes !== 4'b1110) begin errors++; $display("FAIL reset_anodes got %b want 1110", anodes); end
        checks++; if (cathodes !== 8'hB0) begin errors++; $display("FAIL reset_cathodes got %h want b0", cathodes); end
        @(negedge clk);
        i_rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_rx_good();
        send_byte(8'hA5, 1'b1);
        checks++; if (converted !== 1'b1) begin errors++; $display("FAIL rx_a5_converted got %b want 1", converted); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL rx_a5_data_valid got %b want 1", data_valid); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL rx_a5_data got %h want a5", data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rx_a5_rx_busy got %b want 0", rx_busy); end
    endtask

    task automatic test_rx_bad_stop_flush();
        send_byte(8'h3C, 1'b0);
        repeat (1000) @(posedge clk);
        #1;
        checks++; if (converted !== 1'b1) begin errors++; $display("FAIL rx_3c_converted got %b want 1", converted); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rx_3c_data_valid got %b want 0", data_valid); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL rx_3c_data got %h want 3c", data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rx_3c_rx_busy got %b want 0", rx_busy); end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (converted !== 1'b0) begin errors++; $display("FAIL flush_converted got %b want 0", converted); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL flush_data_valid got %b want 0", data_valid); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL flush_data_kept got %h want 3c", data); end
    endtask

    task automatic test_rx_glitch();
        logic saw_busy;
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (rx_busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rose got %b want 1", saw_busy); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fell got %b want 0", rx_busy); end
        checks++; if (converted !== 1'b0) begin errors++; $display("FAIL glitch_converted got %b want 0", converted); end
    endtask

    task automatic test_tx();
        logic [9:0] exp_bits;
        exp_bits = {1'b1, 8'h5A, 1'b0};
        do begin @(posedge clk); #1; end while (cyc % TICK_DIV != 0);
        tx_data   = 8'h5A;
        tx_enable = 1'b1;
        @(posedge clk);
        #1;
        tx_enable = 1'b0;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_rise got %b want 1", tx_busy); end
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? BIT_CLKS / 2 : BIT_CLKS) @(posedge clk);
            #1;
            checks++;
            if (tx !== exp_bits[i]) begin errors++; $display("FAIL tx_bit%0d got %b want %b", i, tx, exp_bits[i]); end
            if (i == 3) begin tx_data = 8'hFF; tx_enable = 1'b1; end
            if (i == 4) tx_enable = 1'b0;
            if (i == 8) begin tx_data = 8'hC3; tx_enable = 1'b1; end
        end
        repeat (BIT_CLKS / 2 - 1) @(posedge clk);
        #1;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_last_clk got %b want 1", tx_busy); end
        @(posedge clk);
        #1;
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_fall got %b want 0", tx_busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_level got %b want 1", tx); end
        @(posedge clk);
        #1;
        tx_enable = 1'b0;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_back_to_back_busy got %b want 1", tx_busy); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_back_to_back_start got %b want 0", tx); end
    endtask

    task automatic test_display();
        logic [3:0] exp_an [4];
        logic [7:0] exp_cat [4];
        int k;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_cat = '{8'h8E, 8'h88, 8'h24, 8'hF9};
        number = 16'h12AF;
        decimal_points = 4'b0100;
        for (int j = 0; j < 4; j++) begin
            do begin @(posedge clk); #1; end while (cyc % DIG_CLKS != DIG_CLKS / 2);
            k = (cyc / DIG_CLKS) % 4;
            checks++; if (anodes !== exp_an[k]) begin errors++; $display("FAIL disp_anodes_d%0d got %b want %b", k, anodes, exp_an[k]); end
            checks++; if (cathodes !== exp_cat[k]) begin errors++; $display("FAIL disp_cathodes_d%0d got %h want %h", k, cathodes, exp_cat[k]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        rx = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_rx_busy got %b want 1", rx_busy); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL mid_tx_busy got %b want 1", tx_busy); end
        i_rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_busy got %b want 0", tx_busy); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_busy got %b want 0", rx_busy); end
        checks++; if (converted !== 1'b0) begin errors++; $display("FAIL rst_mid_converted got %b want 0", converted); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_data_valid got %b want 0", data_valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", data); end
        checks++; if (anodes !== 4'b1110) begin errors++; $display("FAIL rst_mid_anodes got %b want 1110", anodes); end
        checks++; if (cathodes !== 8'h8E) begin errors++; $display("FAIL rst_mid_cathodes got %h want 8e", cathodes); end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (100) @(posedge clk);
        send_byte(8'h96, 1'b1);
        checks++; if (converted !== 1'b1) begin errors++; $display("FAIL post_rst_converted got %b want 1", converted); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL post_rst_data_valid got %b want 1", data_valid); end
        checks++; if (data !== 8'h96) begin errors++; $display("FAIL post_rst_data got %h want 96", data); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL post_rst_tx_busy got %b want 0", tx_busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL post_rst_tx got %b want 1", tx); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout got no finish want finish before 5000000");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rx_good();
        test_rx_bad_stop_flush();
        test_rx_glitch();
        test_tx();
        test_display();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
